irled_seq_ctrl: RTL and testbench
=================================

// Module: irled_seq_ctrl
// PURPOSE
//  Sequencer for the 500 mA IR LED driver macro: power-up bias, soft-start current ramp, carrier PWM.
//  Drives irled_en, cbit_ir_en, cbit_ir[9:0] and ir_pwm from fabric symbols (mark/space x N carrier periods).
//  Sits between the fabric transmit logic and the IR driver macro.
//  Guarantees the bias is settled before any pulse, and that current is never stepped from 0 to full code.
// PARAMETERS
//  CNT_W          16  width of carrier period/duty/length counters
//  SETTLE_CYC     64  clocks between bias enable and first current step (ir_nref/ir_vref settle)
//  RAMP_STEP_CYC  16  clocks per soft-start current step
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-high reset
//  poc          in   1      power-on-clear from IO ring; forces shutdown
//  cfg_en       in   1      global IR enable
//  cfg_ramp     in   1      1 = soft-start ramp, 0 = apply full code after settle
//  cfg_code     in   10     target driver code (bit-parallel current legs)
//  cfg_period   in   CNT_W  carrier period in clocks (values <2 clamped to 2)
//  cfg_duty     in   CNT_W  carrier high time in clocks (>= period -> solid high)
//  tx_valid     in   1      symbol valid
//  tx_ready     out  1      symbol accept; transfer when tx_valid & tx_ready
//  tx_mark      in   1      1 = carrier during symbol, 0 = space (ir_pwm low)
//  tx_len       in   CNT_W  symbol length in carrier periods (0 treated as 1)
//  irled_en     out  1      bias enable to driver
//  cbit_ir_en   out  1      IR code enable to driver
//  cbit_ir      out  10     driver current legs
//  ir_pwm       out  1      carrier gate
//  busy         out  1      state != OFF
// BEHAVIOUR
//  Reset: state OFF; all outputs 0 (tx_ready, irled_en, cbit_ir_en, cbit_ir, ir_pwm, busy). All outputs registered.
//  States: OFF -> SETTLE -> RAMP -> ACTIVE <-> TX; any state -> OFF on poc.
//  OFF: cfg_en & !poc -> SETTLE; latch cfg_code into code_q. cfg_code changes are ignored until next OFF exit.
//  SETTLE: irled_en=cbit_ir_en=1, cbit_ir=0 for exactly SETTLE_CYC clocks.
//    Then RAMP if cfg_ramp & code_q!=0; else ACTIVE with cbit_ir=code_q.
//  RAMP: every RAMP_STEP_CYC clocks, set the lowest bit of (code_q & ~cbit_ir).
//    When cbit_ir==code_q -> ACTIVE (same edge as the last step).
//  ACTIVE: tx_ready=1. Accept latches tx_mark, tx_len, cfg_period, cfg_duty -> TX next edge; tx_ready drops.
//  TX: carrier count c runs 0..period-1; ir_pwm = mark & (c < duty); period count increments on c wrap.
//    After len periods -> ACTIVE. One-clock gap (ready, pwm=0) between back-to-back symbols.
//  cfg_en low: in SETTLE/RAMP/ACTIVE -> OFF next edge. In TX the current symbol completes, then -> OFF.
//  poc high: -> OFF next edge from any state. ir_pwm gated combinationally by !poc.
//    Symbol in flight is dropped; no tx_ready while poc.
//  OFF entry clears cbit_ir, cbit_ir_en, irled_en, ir_pwm on the same edge.
//    Re-enable always re-runs SETTLE (and RAMP).
//  Counters saturate/wrap only inside their CNT_W range; no arithmetic overflow is visible at the outputs.
// STRUCTURE
//  Package irled_pkg: state enum {OFF,SETTLE,RAMP,ACTIVE,TX}, IR_CODE_W=10, clamp constant PERIOD_MIN=2.
//  Sub-module irled_carrier_gen: period/duty/length counters.
//    Inputs: start, mark, period, duty, len. Outputs: pwm, done (1-clk pulse on the last clock of the symbol).
//  FSM and ramp logic stay in irled_seq_ctrl.
// TESTING
//  1 Reset, cfg_en=1, cfg_ramp=0, code=10'h3FF -> irled_en=1 at +1 clk; cbit_ir=0x3FF exactly 64 clks later; tx_ready=1.
//  2 cfg_ramp=1, code=10'b1000010101 -> cbit_ir steps 001,005,015,215 every 16 clks; then ACTIVE.
//  3 period=10, duty=3, mark=1, len=4 -> 4 pulses of 3 clks high per 10 clks, ir_pwm low after, tx_ready back.
//  4 mark=0, len=0 -> ir_pwm stays 0 for 1 period (10 clks); duty=12, period=10 -> solid high 40 clks for len=4.
//  5 poc pulsed mid-TX -> ir_pwm 0 same cycle; all outputs 0 next edge; re-enable re-runs 64-clk settle.
//  6 cfg_en dropped mid-symbol -> symbol finishes full len; then OFF; cfg_code change while ACTIVE has no effect on cbit_ir.

Source files
------------

// File: rtl/irled_pkg.sv
// Shared definitions for the IR LED driver sequencer.
//   irled_state_e : sequencer states
//   IR_CODE_W     : width of the driver current-leg code
//   PERIOD_MIN    : smallest carrier period that is honoured (shorter requests are clamped)
//   lowest_bit()  : isolates the least significant set bit of a code word
package irled_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    SETTLE = 3'd1,
    RAMP   = 3'd2,
    ACTIVE = 3'd3,
    TX     = 3'd4
  } irled_state_e;

  localparam int IR_CODE_W  = 10;
  localparam int PERIOD_MIN = 2;

  // x & -x keeps only the lowest set bit (zero stays zero).
  function automatic logic [IR_CODE_W-1:0] lowest_bit(input logic [IR_CODE_W-1:0] x);
    return x & ((~x) + IR_CODE_W'(1));
  endfunction

endpackage

// File: rtl/irled_carrier_gen.sv
// Carrier generator for one transmit symbol.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load mark/period/duty/len and begin the symbol
//   abort    : drop the symbol immediately
//   mark     : 1 = carrier, 0 = space (pwm held low)
//   period   : carrier period in clocks (clamped to PERIOD_MIN)
//   duty     : carrier high clocks per period (>= period gives solid high)
//   len      : symbol length in carrier periods (0 treated as 1)
//   pwm      : registered carrier gate
//   done     : high on the last clock of the symbol
module irled_carrier_gen import irled_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mark,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] len,
  output logic             pwm,
  output logic             done
);

  logic             active;
  logic             pwm_q;
  logic             mark_q;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] last_c;
  logic [CNT_W-1:0] last_n;
  logic [CNT_W-1:0] c;
  logic [CNT_W-1:0] n;
  logic             c_wrap;

  // Terminal values are stored as period-1 / len-1 so no subtraction sits in the compare path.
  assign c_wrap = (c == last_c);
  assign done   = active & c_wrap & (n == last_n);
  assign pwm    = pwm_q;

  always_ff @(posedge clk) begin
    if (start) begin
      mark_q <= mark;
      duty_q <= duty;
      last_c <= (period < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN - 1) : period - CNT_W'(1);
      last_n <= (len == '0) ? '0 : len - CNT_W'(1);
      c      <= '0;
      n      <= '0;
    end else if (active) begin
      if (c_wrap) begin
        c <= '0;
        n <= n + CNT_W'(1);
      end else begin
        c <= c + CNT_W'(1);
      end
    end
  end

  // pwm is registered from the value the carrier count takes on this edge;
  // c < last_c whenever c+1 is formed, so the increment cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      pwm_q  <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
      pwm_q  <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      pwm_q  <= mark & (duty != '0);
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
        pwm_q  <= 1'b0;
      end else if (c_wrap) begin
        pwm_q <= mark_q & (duty_q != '0);
      end else begin
        pwm_q <= mark_q & ((c + CNT_W'(1)) < duty_q);
      end
    end
  end

endmodule

// File: rtl/irled_seq_ctrl.sv
// Sequencer for the 500 mA IR LED driver macro: bias settle, soft-start current
// ramp, then carrier-modulated symbols from the fabric.
//   clk, rst             : clock, asynchronous active-high reset
//   poc                  : power-on-clear, forces shutdown
//   cfg_en               : global IR enable
//   cfg_ramp             : 1 = soft-start ramp, 0 = full code after settle
//   cfg_code             : target driver code, latched on leaving OFF
//   cfg_period, cfg_duty : carrier period / high time, latched per symbol
//   tx_valid, tx_ready   : symbol handshake
//   tx_mark, tx_len      : symbol type and length in carrier periods
//   irled_en, cbit_ir_en : bias enable / code enable to the driver
//   cbit_ir              : driver current legs
//   ir_pwm               : carrier gate (forced low while poc)
//   busy                 : sequencer not in OFF
module irled_seq_ctrl import irled_pkg::*; #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYC    = 64,
  parameter int RAMP_STEP_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 poc,
  input  logic                 cfg_en,
  input  logic                 cfg_ramp,
  input  logic [IR_CODE_W-1:0] cfg_code,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic [CNT_W-1:0]     cfg_duty,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 tx_mark,
  input  logic [CNT_W-1:0]     tx_len,
  output logic                 irled_en,
  output logic                 cbit_ir_en,
  output logic [IR_CODE_W-1:0] cbit_ir,
  output logic                 ir_pwm,
  output logic                 busy
);

  irled_state_e         state, state_n;
  logic [CNT_W-1:0]     tmr, tmr_n;
  logic [IR_CODE_W-1:0] code_q;
  logic [IR_CODE_W-1:0] cbit_q, cbit_n;
  logic [IR_CODE_W-1:0] step_bit;
  logic                 en_q, ready_q;
  logic                 latch_code;
  logic                 accept;
  logic                 sym_pwm, sym_done;

  assign tx_ready   = ready_q & ~poc;
  assign accept     = tx_valid & tx_ready;
  assign irled_en   = en_q;
  assign cbit_ir_en = en_q;
  assign busy       = en_q;
  assign cbit_ir    = cbit_q;
  assign ir_pwm     = sym_pwm & ~poc;
  assign step_bit   = lowest_bit(code_q & ~cbit_q);

  irled_carrier_gen #(.CNT_W(CNT_W)) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .abort  (poc),
    .mark   (tx_mark),
    .period (cfg_period),
    .duty   (cfg_duty),
    .len    (tx_len),
    .pwm    (sym_pwm),
    .done   (sym_done)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n    = state;
    tmr_n      = tmr;
    cbit_n     = cbit_q;
    latch_code = 1'b0;
    if (poc) begin
      state_n = OFF;
    end else begin
      case (state)
        OFF: begin
          if (cfg_en) begin
            state_n    = SETTLE;
            tmr_n      = '0;
            latch_code = 1'b1;
          end
        end
        SETTLE: begin
          if (!cfg_en) begin
            state_n = OFF;
          end else if (tmr == CNT_W'(SETTLE_CYC - 1)) begin
            tmr_n = '0;
            if (cfg_ramp && code_q != '0) begin
              state_n = RAMP;
            end else begin
              state_n = ACTIVE;
              cbit_n  = code_q;
            end
          end else begin
            tmr_n = tmr + CNT_W'(1);
          end
        end
        RAMP: begin
          if (!cfg_en) begin
            state_n = OFF;
          end else if (tmr == CNT_W'(RAMP_STEP_CYC - 1)) begin
            tmr_n  = '0;
            cbit_n = cbit_q | step_bit;
            if ((cbit_q | step_bit) == code_q) state_n = ACTIVE;
          end else begin
            tmr_n = tmr + CNT_W'(1);
          end
        end
        ACTIVE: begin
          // A handshake that completes wins over cfg_en low: the symbol was
          // accepted, so it is sent before shutting down.
          if (accept)       state_n = TX;
          else if (!cfg_en) state_n = OFF;
        end
        TX: begin
          if (sym_done) state_n = cfg_en ? ACTIVE : OFF;
        end
        default: state_n = OFF;
      endcase
    end
    if (state_n == OFF) cbit_n = '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      tmr     <= '0;
      cbit_q  <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      cbit_q  <= cbit_n;
      en_q    <= (state_n != OFF);
      ready_q <= (state_n == ACTIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (latch_code) code_q <= cfg_code;
  end

endmodule

// File: tb/tb_irled_seq_ctrl.sv
// Self-checking bench for irled_seq_ctrl.
module tb_irled_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        poc;
  logic        cfg_en;
  logic        cfg_ramp;
  logic [9:0]  cfg_code;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_mark;
  logic [15:0] tx_len;
  logic        irled_en;
  logic        cbit_ir_en;
  logic [9:0]  cbit_ir;
  logic        ir_pwm;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;
  logic exp_q[$];
  logic [9:0] ramp_q[$];

  irled_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .poc        (poc),
    .cfg_en     (cfg_en),
    .cfg_ramp   (cfg_ramp),
    .cfg_code   (cfg_code),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_mark    (tx_mark),
    .tx_len     (tx_len),
    .irled_en   (irled_en),
    .cbit_ir_en (cbit_ir_en),
    .cbit_ir    (cbit_ir),
    .ir_pwm     (ir_pwm),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_off(input string tag);
    chk_eq({tag, "_irled_en"}, 32'(irled_en), 32'd0);
    chk_eq({tag, "_cbit_en"}, 32'(cbit_ir_en), 32'd0);
    chk_eq({tag, "_cbit"}, 32'(cbit_ir), 32'd0);
    chk_eq({tag, "_pwm"}, 32'(ir_pwm), 32'd0);
    chk_eq({tag, "_ready"}, 32'(tx_ready), 32'd0);
    chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Enable from OFF with no ramp and check the settle length and final code.
  task automatic settle_direct(input string tag, input logic [9:0] code);
    cfg_en = 1'b1;
    step(1);
    chk_eq({tag, "_bias_on"}, 32'(irled_en), 32'd1);
    chk_eq({tag, "_cbit_en_on"}, 32'(cbit_ir_en), 32'd1);
    step(63);
    chk_eq({tag, "_cbit_settling"}, 32'(cbit_ir), 32'd0);
    chk_eq({tag, "_ready_settling"}, 32'(tx_ready), 32'd0);
    step(1);
    chk_eq({tag, "_cbit_final"}, 32'(cbit_ir), 32'(code));
    chk_eq({tag, "_ready_final"}, 32'(tx_ready), 32'd1);
  endtask

  // Push the expected per-clock carrier pattern, send the symbol, then pop and compare.
  task automatic send_sym(input string tag, input logic mark, input int len, input int period,
                          input int duty, input int drop_at);
    int pe, le, waited, idx;
    logic e, exp_end;
    pe = (period < 2) ? 2 : period;
    le = (len == 0) ? 1 : len;
    for (int n = 0; n < le; n++)
      for (int c = 0; c < pe; c++)
        exp_q.push_back(mark && (c < duty));
    waited = 0;
    while (!tx_ready && waited < 200) begin
      step(1);
      waited++;
    end
    if (!tx_ready) begin
      chk_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    tx_mark    = mark;
    tx_len     = 16'(len);
    cfg_period = 16'(period);
    cfg_duty   = 16'(duty);
    tx_valid   = 1'b1;
    step(1);
    tx_valid   = 1'b0;
    chk_eq({tag, "_ready_drop"}, 32'(tx_ready), 32'd0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_eq($sformatf("%s_pwm[%0d]", tag, idx), 32'(ir_pwm), 32'(e));
      if (idx == drop_at) cfg_en = 1'b0;
      step(1);
      idx++;
    end
    exp_end = cfg_en;
    chk_eq({tag, "_pwm_after"}, 32'(ir_pwm), 32'd0);
    chk_eq({tag, "_ready_after"}, 32'(tx_ready), 32'(exp_end));
    chk_eq({tag, "_busy_after"}, 32'(busy), 32'(exp_end));
  endtask

  initial begin
    int cyc;
    logic [9:0] prev, e;
    rst = 1'b1; poc = 1'b0; cfg_en = 1'b0; cfg_ramp = 1'b0; cfg_code = '0;
    cfg_period = '0; cfg_duty = '0; tx_valid = 1'b0; tx_mark = 1'b0; tx_len = '0;
    step(2);
    chk_off("reset");
    rst = 1'b0;

    // Direct settle to full code.
    cfg_code = 10'h3FF;
    settle_direct("t1", 10'h3FF);
    cfg_en = 1'b0;
    step(1);
    chk_off("t1_off");

    // Soft-start ramp.
    cfg_ramp = 1'b1;
    cfg_code = 10'h215;
    cfg_en   = 1'b1;
    ramp_q.push_back(10'h001);
    ramp_q.push_back(10'h005);
    ramp_q.push_back(10'h015);
    ramp_q.push_back(10'h215);
    step(65);
    chk_eq("t2_ramp_start_cbit", 32'(cbit_ir), 32'd0);
    chk_eq("t2_ramp_start_ready", 32'(tx_ready), 32'd0);
    prev = 10'h000;
    while (ramp_q.size() > 0) begin
      e = ramp_q.pop_front();
      cyc = 0;
      while (cbit_ir == prev && cyc < 100) begin
        step(1);
        cyc++;
      end
      chk_eq("t2_step_cycles", 32'(cyc), 32'd16);
      chk_eq("t2_step_value", 32'(cbit_ir), 32'(e));
      prev = cbit_ir;
    end
    chk_eq("t2_ready_active", 32'(tx_ready), 32'd1);

    // Carrier symbols, including back-to-back and boundary cases.
    send_sym("t3", 1'b1, 4, 10, 3, -1);
    send_sym("t4_space", 1'b0, 0, 10, 3, -1);
    send_sym("t4_solid", 1'b1, 4, 10, 12, -1);
    send_sym("t4_clamp", 1'b1, 2, 1, 1, -1);

    // Code change while ACTIVE is ignored; cfg_en drop mid-symbol lets it finish.
    cfg_code = 10'h0F0;
    step(3);
    chk_eq("t6_code_held", 32'(cbit_ir), 32'h215);
    send_sym("t6", 1'b1, 3, 4, 2, 5);
    chk_off("t6_off");

    // New code is taken on the next OFF exit.
    cfg_ramp = 1'b0;
    settle_direct("t6_reen", 10'h0F0);

    // No tx_ready while poc in ACTIVE.
    poc = 1'b1;
    #1;
    chk_eq("t5_ready_poc", 32'(tx_ready), 32'd0);
    @(negedge clk);
    chk_off("t5_active_poc");
    poc = 1'b0;
    settle_direct("t5a", 10'h0F0);

    // poc mid-symbol.
    tx_mark = 1'b1; tx_len = 16'd4; cfg_period = 16'd10; cfg_duty = 16'd10;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(3);
    chk_eq("t5_pwm_before", 32'(ir_pwm), 32'd1);
    poc = 1'b1;
    #1;
    chk_eq("t5_pwm_gated", 32'(ir_pwm), 32'd0);
    @(negedge clk);
    chk_off("t5_tx_poc");
    poc = 1'b0;
    settle_direct("t5b", 10'h0F0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
